// File: rtl/mux_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux_arb_pkg
//   Shared definitions for the arbitrated N:1 register-slice multiplexer.
//   - MODE_RR / MODE_FIXED : arbitration mode encodings.
//   - ch_w()               : width of a channel index, never less than 1.
// ---------------------------------------------------------------------------
package mux_arb_pkg;

    localparam int MODE_RR    = 0;  // round-robin from a rotating pointer
    localparam int MODE_FIXED = 1;  // fixed priority, lowest index wins

    // A single channel still needs a 1-bit index port.
    function automatic int ch_w(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Purely combinational winner selection.
//   Searches channels starting at 'ptr' (or at 0 in fixed-priority mode),
//   wrapping past NUM_CH-1 back to 0; the first asserted request wins.
//
//   Ports
//     req   [NUM_CH-1:0] in  : request vector, bit i = channel i
//     ptr   [CH_W-1:0]   in  : round-robin search start
//     mode               in  : 0 = round-robin, 1 = fixed priority
//     grant [NUM_CH-1:0] out : one-hot winner, zero when no request
//     index [CH_W-1:0]   out : binary index of the winner (0 when none)
// ---------------------------------------------------------------------------
module rr_pick
    import mux_arb_pkg::*;
#(
    parameter int NUM_CH = 5,
    parameter int CH_W   = 3
)(
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    input  logic              mode,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   index
);

    always_comb begin
        int   start;
        int   c;
        logic found;
        // NOTE: every output and temporary gets a default before any
        // conditional assignment, so no path can leave a value held (latch).
        grant = '0;
        index = '0;
        found = 1'b0;
        c     = 0;
        // Out-of-range pointers cannot occur, but clamping keeps every
        // index below NUM_CH for any CH_W/NUM_CH combination.
        start = (mode || int'(ptr) >= NUM_CH) ? 0 : int'(ptr);
        for (int k = 0; k < NUM_CH; k++) begin
            c = start + k;
            if (c >= NUM_CH) begin
                c = c - NUM_CH;
            end
            if (!found && req[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                index    = CH_W'(c);
            end
        end
    end

endmodule

// File: rtl/mux_arb_rr.sv
// ---------------------------------------------------------------------------
// mux_arb_rr
//   NUM_CH-input arbitrated multiplexer feeding a single output register
//   slice with valid/ready handshakes on both sides. Latency 1, one word per
//   cycle sustained; the register may drain and reload in the same cycle.
//
//   Ports
//     clk, rst                   : clock, asynchronous active-high reset
//     in_valid  [NUM_CH-1:0]     : per-channel request
//     in_data   [NUM_CH*WIDTH-1:0]: channel i at [i*WIDTH +: WIDTH]
//     in_ready  [NUM_CH-1:0]     : combinational accept, one-hot or zero
//     out_valid                  : output register holds a word
//     out_ready                  : downstream accepts the word
//     out_data  [WIDTH-1:0]      : registered selected word
//     out_ch    [CH_W-1:0]       : channel that supplied out_data
// ---------------------------------------------------------------------------
module mux_arb_rr
    import mux_arb_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int NUM_CH = 5,
    parameter int MODE   = MODE_RR
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         in_valid,
    input  logic [NUM_CH*WIDTH-1:0]   in_data,
    output logic [NUM_CH-1:0]         in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [ch_w(NUM_CH)-1:0]   out_ch
);

    localparam int              CH_W    = ch_w(NUM_CH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    logic              valid_q, valid_d;
    logic [WIDTH-1:0]  data_q,  data_d;
    logic [CH_W-1:0]   ch_q,    ch_d;
    logic [CH_W-1:0]   ptr_q,   ptr_d;

    logic              free;
    logic              take;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   pick_idx;
    logic [WIDTH-1:0]  sel_data;

    // The slice can load when empty or when its word leaves this cycle.
    // Requests are masked off entirely while full-and-stalled or in reset,
    // so in_ready stays zero and input changes cannot disturb state.
    assign free = !valid_q || out_ready;
    assign req  = (free && !rst) ? in_valid : '0;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .mode  (MODE == MODE_FIXED),
        .grant (grant),
        .index (pick_idx)
    );

    assign in_ready = grant;
    assign take     = |grant;

    // AND-OR mux: grant is one-hot or zero, so at most one term survives.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
        if (free) begin
            valid_d = take;
        end
        if (take) begin
            data_d = sel_data;
            ch_d   = pick_idx;
        end
        // Round-robin restarts the search just after the last winner.
        if (MODE == MODE_FIXED) begin
            ptr_d = '0;
        end else if (take) begin
            ptr_d = (pick_idx == LAST_CH) ? '0 : pick_idx + 1'b1;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so
    // every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_ch    = ch_q;

endmodule

// File: tb/tb_mux_arb_rr.sv
// ---------------------------------------------------------------------------
// tb_mux_arb_rr
//   Two instances share all inputs: one round-robin, one fixed priority,
//   both NUM_CH = 5, WIDTH = 4. Directed scenarios use hand-derived values;
//   the randomized phase compares against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_mux_arb_rr;

    localparam int W  = 4;
    localparam int N  = 5;
    localparam int CW = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     in_valid  = '0;
    logic [N*W-1:0]   in_data   = '0;
    logic             out_ready = 1'b0;

    logic [N-1:0]     rr_in_ready,  fx_in_ready;
    logic             rr_out_valid, fx_out_valid;
    logic [W-1:0]     rr_out_data,  fx_out_data;
    logic [CW-1:0]    rr_out_ch,    fx_out_ch;

    int passed = 0;
    int total  = 0;

    // Model state: contents of the output register and the search pointer.
    bit       rr_v, fx_v;
    logic [W-1:0] rr_d, fx_d;
    int       rr_c, fx_c, rr_ptr;

    always #5 clk = ~clk;

    mux_arb_rr #(.WIDTH(W), .NUM_CH(N), .MODE(0)) dut_rr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rr_in_ready), .out_valid(rr_out_valid), .out_ready(out_ready),
        .out_data(rr_out_data), .out_ch(rr_out_ch)
    );

    mux_arb_rr #(.WIDTH(W), .NUM_CH(N), .MODE(1)) dut_fx (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(fx_in_ready), .out_valid(fx_out_valid), .out_ready(out_ready),
        .out_data(fx_out_data), .out_ch(fx_out_ch)
    );

    // First requesting channel when walking start, start+1, ... modulo N.
    function automatic int pick(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready(input bit held, input int start);
        int w;
        w = pick(in_valid, start);
        if (rst || (held && !out_ready) || w < 0) return '0;
        return N'(1) << w;
    endfunction

    function automatic logic [W-1:0] chd(input int i);
        return in_data[i*W +: W];
    endfunction

    task automatic model_clear();
        rr_v = 0; rr_d = '0; rr_c = 0; rr_ptr = 0;
        fx_v = 0; fx_d = '0; fx_c = 0;
    endtask

    // One clock: predict from pre-edge inputs, advance, settle 1 ns.
    task automatic tick();
        int wr, wf;
        bit rr_free, fx_free;
        logic [W-1:0] dr, df;
        rr_free = !rr_v || out_ready;
        fx_free = !fx_v || out_ready;
        wr = pick(in_valid, rr_ptr);
        wf = pick(in_valid, 0);
        dr = (wr >= 0) ? chd(wr) : '0;
        df = (wf >= 0) ? chd(wf) : '0;
        @(posedge clk);
        if (rr_free) begin
            rr_v = (wr >= 0);
            if (wr >= 0) begin rr_d = dr; rr_c = wr; rr_ptr = (wr + 1) % N; end
        end
        if (fx_free) begin
            fx_v = (wf >= 0);
            if (wf >= 0) begin fx_d = df; fx_c = wf; end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic rand_data();
        in_data = N*W'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        in_valid = '1;
        rand_data();
        #1;
        total++;
        if ({rr_out_valid, rr_out_data, rr_out_ch} !== '0 || rr_in_ready !== '0)
            $display("FAIL reset_init: got v=%b d=%h ch=%0d rdy=%b want all 0",
                     rr_out_valid, rr_out_data, rr_out_ch, rr_in_ready);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (rr_out_valid !== 1'b0 || rr_in_ready !== '0 || fx_in_ready !== '0)
            $display("FAIL reset_held: got v=%b rdy=%b/%b want 0", rr_out_valid, rr_in_ready, fx_in_ready);
        else passed++;
        // First edge after release must accept.
        rst = 1'b0;
        model_clear();
        in_valid = 5'b00001;
        in_data[0 +: W] = 4'hA;
        tick();
        total++;
        if (rr_out_valid !== 1'b1 || rr_out_data !== 4'hA || rr_out_ch !== 3'd0)
            $display("FAIL reset_first_accept: got v=%b d=%h ch=%0d want 1 a 0",
                     rr_out_valid, rr_out_data, rr_out_ch);
        else passed++;
        // Asynchronous clear mid-cycle, no clock edge in between.
        out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if (rr_out_valid !== 1'b0 || rr_out_data !== 4'h0 || rr_out_ch !== 3'd0 || fx_out_valid !== 1'b0)
            $display("FAIL reset_async: got v=%b d=%h ch=%0d want 0 0 0",
                     rr_out_valid, rr_out_data, rr_out_ch);
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_fairness();
        do_reset();
        out_ready = 1'b1;
        in_valid = '1;
        for (int i = 0; i < 10; i++) begin
            logic [W-1:0] want;
            rand_data();
            want = chd(i % N);
            #1;
            total++;
            if (rr_in_ready !== N'(1) << (i % N))
                $display("FAIL fair_ready[%0d]: got %b want %b", i, rr_in_ready, N'(1) << (i % N));
            else passed++;
            tick();
            total++;
            if (rr_out_valid !== 1'b1 || rr_out_ch !== CW'(i % N) || rr_out_data !== want)
                $display("FAIL fair_out[%0d]: got v=%b ch=%0d d=%h want 1 %0d %h",
                         i, rr_out_valid, rr_out_ch, rr_out_data, i % N, want);
            else passed++;
        end
    endtask

    task automatic test_wrap_skip();
        do_reset();
        out_ready = 1'b1;
        in_valid = 5'b01000;          // channel 3 wins, pointer moves to 4
        rand_data();
        tick();
        in_valid = 5'b00110;
        #1;
        total++;
        if (rr_in_ready !== 5'b00010)
            $display("FAIL wrap_ready1: got %b want 00010", rr_in_ready);
        else passed++;
        tick();
        total++;
        if (rr_out_ch !== 3'd1 || rr_out_valid !== 1'b1)
            $display("FAIL wrap_grant1: got ch=%0d v=%b want 1 1", rr_out_ch, rr_out_valid);
        else passed++;
        total++;
        if (rr_in_ready !== 5'b00100)
            $display("FAIL wrap_ready2: got %b want 00100", rr_in_ready);
        else passed++;
        tick();
        total++;
        if (rr_out_ch !== 3'd2 || rr_out_data !== chd(2))
            $display("FAIL wrap_grant2: got ch=%0d d=%h want 2 %h", rr_out_ch, rr_out_data, chd(2));
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] want;
        do_reset();
        out_ready = 1'b1;
        in_valid = 5'b00001;
        in_data[0 +: W] = 4'h3;
        tick();
        out_ready = 1'b0;
        in_valid = '1;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            #1;
            total++;
            if (rr_in_ready !== '0 || fx_in_ready !== '0)
                $display("FAIL bp_ready[%0d]: got %b/%b want 0", i, rr_in_ready, fx_in_ready);
            else passed++;
            tick();
            total++;
            if (rr_out_valid !== 1'b1 || rr_out_data !== 4'h3 || rr_out_ch !== 3'd0)
                $display("FAIL bp_hold[%0d]: got v=%b d=%h ch=%0d want 1 3 0",
                         i, rr_out_valid, rr_out_data, rr_out_ch);
            else passed++;
        end
        out_ready = 1'b1;
        rand_data();
        want = chd(1);
        #1;
        total++;
        if (rr_in_ready !== 5'b00010 || fx_in_ready !== 5'b00001)
            $display("FAIL bp_release_ready: got %b/%b want 00010/00001", rr_in_ready, fx_in_ready);
        else passed++;
        tick();
        total++;
        if (rr_out_valid !== 1'b1 || rr_out_ch !== 3'd1 || rr_out_data !== want)
            $display("FAIL bp_drain_load: got v=%b ch=%0d d=%h want 1 1 %h",
                     rr_out_valid, rr_out_ch, rr_out_data, want);
        else passed++;
    endtask

    task automatic test_fixed();
        do_reset();
        out_ready = 1'b1;
        in_valid = 5'b10100;
        for (int i = 0; i < 3; i++) begin
            logic [W-1:0] want;
            rand_data();
            want = chd(2);
            #1;
            total++;
            if (fx_in_ready !== 5'b00100)
                $display("FAIL fixed_ready[%0d]: got %b want 00100", i, fx_in_ready);
            else passed++;
            tick();
            total++;
            if (fx_out_valid !== 1'b1 || fx_out_ch !== 3'd2 || fx_out_data !== want)
                $display("FAIL fixed_out[%0d]: got v=%b ch=%0d d=%h want 1 2 %h",
                         i, fx_out_valid, fx_out_ch, fx_out_data, want);
            else passed++;
        end
    endtask

    task automatic test_idle();
        do_reset();
        out_ready = 1'b1;
        in_valid = 5'b01000;
        rand_data();
        in_data[3*W +: W] = 4'h7;
        tick();
        total++;
        if (rr_out_valid !== 1'b1 || rr_out_data !== 4'h7 || rr_out_ch !== 3'd3)
            $display("FAIL idle_load: got v=%b d=%h ch=%0d want 1 7 3", rr_out_valid, rr_out_data, rr_out_ch);
        else passed++;
        in_valid = '0;
        rand_data();
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (rr_out_valid !== 1'b0 || rr_out_data !== 4'h7 || rr_out_ch !== 3'd3)
                $display("FAIL idle_retain[%0d]: got v=%b d=%h ch=%0d want 0 7 3",
                         i, rr_out_valid, rr_out_data, rr_out_ch);
            else passed++;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] er, ef;
            in_valid  = N'($urandom);
            rand_data();
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            er = exp_ready(rr_v, rr_ptr);
            ef = exp_ready(fx_v, 0);
            total++;
            if (rr_in_ready !== er || fx_in_ready !== ef)
                $display("FAIL rand_ready[%0d]: got %b/%b want %b/%b", i, rr_in_ready, fx_in_ready, er, ef);
            else passed++;
            tick();
            total++;
            if ({rr_out_valid, rr_out_ch, rr_out_data} !== {rr_v, CW'(rr_c), rr_d} ||
                {fx_out_valid, fx_out_ch, fx_out_data} !== {fx_v, CW'(fx_c), fx_d})
                $display("FAIL rand_out[%0d]: got rr %b/%0d/%h fx %b/%0d/%h want rr %b/%0d/%h fx %b/%0d/%h",
                         i, rr_out_valid, rr_out_ch, rr_out_data, fx_out_valid, fx_out_ch, fx_out_data,
                         rr_v, rr_c, rr_d, fx_v, fx_c, fx_d);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_wrap_skip();
        test_backpressure();
        test_fixed();
        test_idle();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0d/%0d", passed, total);
        $fatal(1, "timeout");
    end

endmodule
